// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: scan-code-set-2 special bytes and frame FSM states.
package ps2_pkg;

  localparam logic [7:0] E0 = 8'hE0;
  localparam logic [7:0] F0 = 8'hF0;
  localparam logic [7:0] E1 = 8'hE1;
  localparam logic [7:0] FA = 8'hFA;
  localparam logic [7:0] AA = 8'hAA;
  localparam logic [7:0] EE = 8'hEE;
  localparam logic [7:0] FE = 8'hFE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Bytes that are acknowledgements or status replies rather than key events.
  function automatic logic is_discard(input logic [7:0] b);
    return (b == E1) || (b == FA) || (b == AA) || (b == EE) ||
           (b == FE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser followed by a debounce: the output follows the pin only
// after FILTER consecutive samples disagree with it.
module ps2_filter #(
  parameter int FILTER = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic filt
);

  localparam int CW = $clog2(FILTER + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= 2'b11;
      filt <= 1'b1;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, folds E0/F0 prefixes
// into a single key event, and flags parity, stop-bit and timeout errors.
//
//   state  | meaning
//   IDLE   | waiting for a falling clock edge with data low (start bit)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | next edge carries the odd-parity bit
//   STOP   | next edge carries the stop bit; byte accepted or rejected
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 16,
  parameter int TIMEOUT = 11200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic       strobe,
  output logic       pressed,
  output logic [7:0] code,
  output logic       ext,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          ck_f, d_f, ck_q, fall;
  state_t        state, state_nxt;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          par;
  logic [TW-1:0] wdog;
  logic          ext_f, brk_f;
  logic          shift_en, par_en, accept, bad, tmo;

  ps2_filter #(.FILTER(FILTER)) u_ck (
    .clock (clock),
    .reset (reset),
    .pin   (ps2Ck),
    .filt  (ck_f)
  );

  ps2_filter #(.FILTER(FILTER)) u_d (
    .clock (clock),
    .reset (reset),
    .pin   (ps2D),
    .filt  (d_f)
  );

  assign fall = ck_q & ~ck_f;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ck_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      ck_q  <= ck_f;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    accept    = 1'b0;
    bad       = 1'b0;
    tmo       = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    if (!d_f) state_nxt = DATA;
        DATA: begin
          shift_en = 1'b1;
          if (bitcnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_en    = 1'b1;
          state_nxt = STOP;
        end
        STOP: begin
          if (d_f && (^{shreg, par})) accept = 1'b1;
          else                        bad    = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE && wdog == TW'(1)) begin
      // Watchdog is a down-counter reloaded on every falling edge.
      tmo       = 1'b1;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg   <= '0;
      bitcnt  <= '0;
      par     <= 1'b0;
      wdog    <= '0;
      ext_f   <= 1'b0;
      brk_f   <= 1'b0;
      strobe  <= 1'b0;
      pressed <= 1'b0;
      code    <= '0;
      ext     <= 1'b0;
      err     <= 1'b0;
    end else begin
      strobe <= 1'b0;
      err    <= bad | tmo;

      if (fall)                           wdog <= TW'(TIMEOUT);
      else if (state != IDLE && wdog != '0) wdog <= wdog - TW'(1);

      if (state == IDLE) bitcnt <= '0;
      if (shift_en) begin
        shreg  <= {d_f, shreg[7:1]};
        bitcnt <= bitcnt + 3'd1;
      end
      if (par_en) par <= d_f;

      if (bad || tmo) begin
        shreg <= '0;
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end

      if (accept) begin
        if (shreg == E0) begin
          ext_f <= 1'b1;
        end else if (shreg == F0) begin
          brk_f <= 1'b1;
        end else begin
          ext_f <= 1'b0;
          brk_f <= 1'b0;
          if (!is_discard(shreg)) begin
            strobe  <= 1'b1;
            pressed <= ~brk_f;
            code    <= shreg;
            ext     <= ext_f;
          end
        end
      end
    end
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 keyboard receiver that produces the `kstrobe`/`kpress`/`kcode` event stream consumed by the ZX48 core's keyboard matrix. It samples the raw PS/2 clock and data pins on the 56 MHz system clock, filters them, and deframes 11-bit device-to-host frames. It resolves the scan-code-set-2 `E0`/`F0` prefixes and emits one strobe per complete key event. It sits in the board wrapper, between the PS/2 pins and the core's keyboard inputs.

## Interface
Parameters:
- `FILTER`, 16: consecutive equal samples required before a filtered pin changes state.
- `TIMEOUT`, 11200: cycles (200 µs at 56 MHz) allowed between falling clock edges inside a frame.

Ports:
- `clock`, in, 1: 56 MHz system clock; the only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `ps2Ck`, in, 1: raw PS/2 clock pin; asynchronous.
- `ps2D`, in, 1: raw PS/2 data pin; asynchronous.
- `strobe`, out, 1: one-cycle pulse when a key event is valid.
- `pressed`, out, 1: 1 = make, 0 = break. Valid with `strobe` and held until the next strobe.
- `code`, out, 8: scan code with all prefixes removed. Held until the next strobe.
- `ext`, out, 1: the event carried an `E0` prefix. Held until the next strobe.
- `err`, out, 1: one-cycle pulse on a parity error, stop-bit error, or timeout.

## Operation
- **Pin conditioning.** Each pin passes through a 2-flop synchroniser, then a filter. The filtered value changes only after `FILTER` consecutive samples differ from the current filtered value.
- **Bit sampling.** A data bit is taken on each falling edge of the filtered clock.
- **Frame FSM:**
  - IDLE: data = 0 at the edge goes to DATA with bit count 0. Data = 1 at the edge is ignored, and the FSM stays in IDLE.
  - DATA: shift 8 bits, LSB first. After bit 7, go to PARITY.
  - PARITY: latch the parity bit and go to STOP.
  - STOP: data = 1 and odd parity correct means the byte is accepted. Anything else pulses `err` and clears the prefix flags. In both cases, go to IDLE.
- **Timeout.** A watchdog counter runs in every state except IDLE and reloads on each falling edge. On reaching `TIMEOUT`: pulse `err`, discard the partial byte, clear the prefix flags, go to IDLE.
- **Accepted-byte decode:**
  - `E0`: set the ext flag; no strobe.
  - `F0`: set the break flag; no strobe.
  - `E1`, `FA`, `AA`, `EE`, `FE`, `00`, `FF`: discarded with no strobe; clear both flags.
  - Any other byte: strobe with `pressed` = !break, `code` = byte, `ext` = ext flag; then clear both flags.
- **Flag ordering.** Prefixes are accepted in either order, e.g. `E0 F0 xx`.
- **Reset values.** All outputs 0. FSM in IDLE. Flags, counters and shift register cleared. Filtered pins preset to 1 (idle bus).
- **Reset mid-frame.** The partial frame is dropped with no `err`. The remaining edges of that frame are then ignored by IDLE until a data-0 edge occurs, so a resynchronising garbage byte may occur. This is acceptable, and at worst it produces an `err`.

## Timing
- **Pin to filtered value.** A raw pin change reaches the filtered value after 2 + `FILTER` cycles. A glitch shorter than `FILTER` cycles has no effect.
- **Strobe latency.** `strobe` (or `err`) is asserted in cycle N+1, where N is the cycle in which the filtered clock falls for the stop bit.
- **Output update.** `code`, `pressed` and `ext` update in the same cycle as `strobe`.
- **Strobe spacing.** At most one strobe per frame, so strobes are at least 11 PS/2 bit times apart.
- **Timeout error.** Asserted in the cycle the counter reaches `TIMEOUT`. The counter width is sized to hold `TIMEOUT`.
- **Event priority.** A falling edge and a timeout cannot coincide, because the edge reloads the counter first.

## Structure
- **Shared package `ps2_pkg`:**
  - Special-byte constants: `E0`, `F0`, `E1`, `FA`, `AA`, `EE`, `FE`.
  - FSM state typedef: IDLE, DATA, PARITY, STOP.
- **Sub-module `ps2_filter`:** synchroniser plus debounce counter, parameterised by `FILTER`. Instantiated twice, once for clock and once for data.
- **Top level:** the frame FSM, watchdog and prefix decoder live in `ps2_rx`.

## Test plan
- **Make code.** Frame byte `1C` with parity 0 → one `strobe`, `pressed`=1, `code`=`1C`, `ext`=0; `err` stays 0.
- **Extended break.** Frames `E0`, `F0`, `75` → exactly one `strobe`, after the third frame, with `pressed`=0, `code`=`75`, `ext`=1. A following `1C` frame gives `ext`=0.
- **Parity error recovery.** `1C` sent with a wrong parity bit → `err` pulse, no `strobe`. The next good `F0 1C` → `strobe` with `pressed`=0, `code`=`1C`.
- **Timeout.** Drive start + 4 data bits, hold the clock high for `TIMEOUT`+10 cycles → one `err` pulse, FSM back in IDLE. A subsequent full `29` frame → `strobe` with `code`=`29`.
- **Glitch rejection.** A clock low pulse of `FILTER`-2 cycles in IDLE produces no state change. A 10-cycle data glitch mid-bit has no effect on the sampled byte.
- **Reset.** Assert `reset` after 6 bits of a frame → all outputs 0, FSM in IDLE. A fresh `E0 70` → `strobe` with `ext`=1, `code`=`70`, `pressed`=1. A `FA` frame → no strobe.
